// File: rtl/int_mult_sched.sv
// rtl/int_mult_sched.sv - round-robin issue scheduler sharing one pipelined int_mult
module int_mult_sched #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_REQ      = 4,
    parameter int MULT_LATENCY = 5,
    parameter int ID_W         = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_plier,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_cand,
    output logic                          mult_en,
    output logic [DATA_WIDTH-1:0]         mult_plier,
    output logic [DATA_WIDTH-1:0]         mult_cand,
    input  logic [2*DATA_WIDTH-1:0]       mult_result,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [ID_W-1:0]               resp_id,
    output logic [2*DATA_WIDTH-1:0]       resp_result,
    output logic                          busy
);

    logic [MULT_LATENCY-1:0] tag_vld;
    logic [ID_W-1:0]         tag_id [MULT_LATENCY];
    logic [ID_W-1:0]         rr_ptr;
    logic [ID_W-1:0]         next_ptr;
    logic [ID_W-1:0]         winner;
    logic                    found;
    logic                    advance;
    logic                    transfer;
    int                      scan_idx;

    // A response held at the pipeline tail freezes both the multiplier and the tags.
    assign advance  = ~(tag_vld[MULT_LATENCY-1] & ~resp_ready);
    assign mult_en  = advance;
    assign transfer = found & advance & rst_n;

    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = int'(rr_ptr) + k;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            if (!found && req_valid[scan_idx]) begin
                found  = 1'b1;
                winner = ID_W'(scan_idx);
            end
        end
    end

    always_comb begin
        req_ready  = '0;
        mult_plier = '0;
        mult_cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (transfer && winner == ID_W'(i)) begin
                req_ready[i] = 1'b1;
                mult_plier   = req_plier[i*DATA_WIDTH +: DATA_WIDTH];
                mult_cand    = req_cand[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign next_ptr = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld <= '0;
            rr_ptr  <= '0;
            for (int k = 0; k < MULT_LATENCY; k++) begin
                tag_id[k] <= '0;
            end
        end else begin
            if (advance) begin
                tag_vld[0] <= transfer;
                tag_id[0]  <= winner;
                for (int k = 1; k < MULT_LATENCY; k++) begin
                    tag_vld[k] <= tag_vld[k-1];
                    tag_id[k]  <= tag_id[k-1];
                end
            end
            if (transfer) begin
                rr_ptr <= next_ptr;
            end
        end
    end

    assign resp_valid  = tag_vld[MULT_LATENCY-1];
    assign resp_id     = tag_id[MULT_LATENCY-1];
    assign resp_result = mult_result;
    assign busy        = |tag_vld;

endmodule

// File: tb/tb_int_mult_sched.sv
// tb/tb_int_mult_sched.sv - directed self-checking bench for int_mult_sched
module tb_int_mult_sched;
    localparam int DW  = 32;
    localparam int NR  = 4;
    localparam int LAT = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*DW-1:0] req_plier;
    logic [NR*DW-1:0] req_cand;
    logic            mult_en;
    logic [DW-1:0]   mult_plier;
    logic [DW-1:0]   mult_cand;
    logic [2*DW-1:0] mult_result;
    logic            resp_valid;
    logic            resp_ready;
    logic [1:0]      resp_id;
    logic [2*DW-1:0] resp_result;
    logic            busy;

    int checks = 0;
    int passes = 0;

    logic [2*DW-1:0] mpipe [LAT];

    int_mult_sched #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MULT_LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_plier(req_plier), .req_cand(req_cand), .mult_en(mult_en),
        .mult_plier(mult_plier), .mult_cand(mult_cand), .mult_result(mult_result),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stand-in for the shared int_mult: LAT enabled stages, frozen when en is low.
    always @(posedge clk) begin
        if (mult_en) begin
            mpipe[0] <= {{DW{1'b0}}, mult_plier} * {{DW{1'b0}}, mult_cand};
            for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
        end
    end
    assign mult_result = mpipe[LAT-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [DW-1:0] p, input logic [DW-1:0] c);
        req_plier[i*DW +: DW] = p;
        req_cand[i*DW +: DW]  = c;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        req_valid = '0;
        resp_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic drain();
        int n = 0;
        req_valid = '0;
        resp_ready = 1'b1;
        while (busy && n < 40) begin tick(); n++; end
        checks++; if (busy !== 1'b0) $display("FAIL drain_busy: got %0b want 0", busy); else passes++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 4'hF;
        resp_ready = 1'b1;
        for (int i = 0; i < NR; i++) set_op(i, 0, 0);
        tick();
        checks++; if (req_ready !== 4'h0) $display("FAIL reset_req_ready: got %0h want 0", req_ready); else passes++;
        checks++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %0b want 0", resp_valid); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else passes++;
        req_valid = '0;
        tick();
        rst_n = 1'b1;
        #1;
        checks++; if (mult_en !== 1'b1) $display("FAIL reset_mult_en: got %0b want 1", mult_en); else passes++;
    endtask

    task automatic test_single();
        int n = 0;
        reset_dut();
        set_op(2, 7, 6);
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) $display("FAIL single_grant: got %0h want 4", req_ready); else passes++;
        checks++; if (mult_plier !== 32'd7 || mult_cand !== 32'd6)
            $display("FAIL single_operands: got %0d,%0d want 7,6", mult_plier, mult_cand); else passes++;
        tick();
        req_valid = '0;
        #1;
        checks++; if (req_ready !== 4'b0000) $display("FAIL single_grant_once: got %0h want 0", req_ready); else passes++;
        checks++; if (busy !== 1'b1) $display("FAIL single_busy: got %0b want 1", busy); else passes++;
        while (!resp_valid && n < 20) begin tick(); n++; end
        checks++; if (n !== LAT - 1) $display("FAIL single_latency: got %0d want %0d", n + 1, LAT); else passes++;
        checks++; if (resp_id !== 2'd2) $display("FAIL single_id: got %0d want 2", resp_id); else passes++;
        checks++; if (resp_result !== 64'd42) $display("FAIL single_result: got %0d want 42", resp_result); else passes++;
        tick();
        checks++; if (resp_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL single_done: got valid=%0b busy=%0b want 0,0", resp_valid, busy); else passes++;
    endtask

    task automatic test_round_robin();
        logic [63:0] prod [NR];
        int errs_g = 0;
        int errs_r = 0;
        prod[0] = 64'd6; prod[1] = 64'd12; prod[2] = 64'd20; prod[3] = 64'd30;
        reset_dut();
        for (int i = 0; i < NR; i++) set_op(i, i + 2, i + 3);
        req_valid = 4'hF;
        for (int n = 0; n < 14; n++) begin
            #1;
            if (req_ready !== 4'(1 << (n % NR))) begin
                errs_g++;
                $display("FAIL rr_grant[%0d]: got %0h want %0h", n, req_ready, 4'(1 << (n % NR)));
            end
            if (n >= LAT) begin
                if (resp_valid !== 1'b1 || resp_id !== 2'((n - LAT) % NR) || resp_result !== prod[(n - LAT) % NR]) begin
                    errs_r++;
                    $display("FAIL rr_resp[%0d]: got v=%0b id=%0d r=%0d want v=1 id=%0d r=%0d",
                             n, resp_valid, resp_id, resp_result, (n - LAT) % NR, prod[(n - LAT) % NR]);
                end
            end
            tick();
        end
        checks++; if (errs_g == 0) passes++;
        checks++; if (errs_r == 0) passes++;
        drain();
    endtask

    task automatic test_backpressure();
        logic [63:0] exp_r [3];
        int errs = 0;
        exp_r[0] = 64'd15; exp_r[1] = 64'd20000; exp_r[2] = 64'hFFFE0001;
        reset_dut();
        set_op(0, 3, 5);
        set_op(1, 100, 200);
        set_op(2, 32'hFFFF, 32'hFFFF);
        resp_ready = 1'b0;
        req_valid = 4'b0001; tick();
        req_valid = 4'b0010; tick();
        req_valid = 4'b0100; tick();
        req_valid = 4'b0000; tick();
        tick();
        req_valid = 4'b1000;
        #1;
        checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_result !== 64'd15)
            $display("FAIL bp_first: got v=%0b id=%0d r=%0d want 1,0,15", resp_valid, resp_id, resp_result); else passes++;
        checks++; if (mult_en !== 1'b0) $display("FAIL bp_mult_en: got %0b want 0", mult_en); else passes++;
        checks++; if (req_ready !== 4'h0) $display("FAIL bp_req_ready: got %0h want 0", req_ready); else passes++;
        for (int n = 0; n < 5; n++) begin
            tick();
            if (resp_valid !== 1'b1 || resp_result !== 64'd15 || mult_en !== 1'b0) errs++;
        end
        checks++; if (errs != 0) $display("FAIL bp_hold: %0d cycles unstable want 0", errs); else passes++;
        req_valid = '0;
        resp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (resp_valid !== 1'b1 || resp_id !== 2'(k) || resp_result !== exp_r[k])
                $display("FAIL bp_resp%0d: got v=%0b id=%0d r=%0h want 1,%0d,%0h", k, resp_valid, resp_id, resp_result, k, exp_r[k]);
            else passes++;
            tick();
        end
        checks++; if (resp_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL bp_no_dup: got v=%0b busy=%0b want 0,0", resp_valid, busy); else passes++;
    endtask

    task automatic test_fairness();
        int n = 0;
        reset_dut();
        for (int i = 0; i < NR; i++) set_op(i, 1, 1);
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) $display("FAIL fair_first: got %0h want 1", req_ready); else passes++;
        tick();
        req_valid = 4'b1001;
        #1;
        while (req_ready !== 4'b1000 && n < NR) begin tick(); n++; end
        checks++; if (req_ready !== 4'b1000) $display("FAIL fair_req3: got %0h want 8 after %0d cycles", req_ready, n); else passes++;
        tick();
        req_valid = 4'b0011;
        #1;
        checks++; if (req_ready !== 4'b0001) $display("FAIL fair_ptr_wrap: got %0h want 1", req_ready); else passes++;
        drain();
    endtask

    task automatic test_max();
        int n = 0;
        reset_dut();
        set_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        while (!resp_valid && n < 20) begin tick(); n++; end
        checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_result !== 64'hFFFF_FFFE_0000_0001)
            $display("FAIL max_result: got v=%0b id=%0d r=%0h want 1,1,fffffffe00000001", resp_valid, resp_id, resp_result);
        else passes++;
        drain();
    endtask

    task automatic test_reset_midflight();
        int stale = 0;
        reset_dut();
        for (int i = 0; i < NR; i++) set_op(i, i + 1, 9);
        req_valid = 4'hF;
        for (int n = 0; n < NR; n++) tick();
        req_valid = '0;
        #1;
        checks++; if (busy !== 1'b1) $display("FAIL mid_busy_before: got %0b want 1", busy); else passes++;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || resp_valid !== 1'b0)
            $display("FAIL mid_async_clear: got busy=%0b v=%0b want 0,0", busy, resp_valid); else passes++;
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (resp_valid !== 1'b0 || busy !== 1'b0) stale++;
        end
        checks++; if (stale != 0) $display("FAIL mid_stale: got %0d stale cycles want 0", stale); else passes++;
        req_valid = 4'b1010;
        #1;
        checks++; if (req_ready !== 4'b0010) $display("FAIL mid_first_grant: got %0h want 2", req_ready); else passes++;
        drain();
    endtask

    initial begin
        req_plier = '0;
        req_cand = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_fairness();
        test_max();
        test_reset_midflight();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
